// File: rtl/tracklet_readout_if.sv
// FIFO-side and link-side signals of the tracklet readout state machine.
// The master modport is the readout SM; the slave modport is the FIFOs plus the link.
interface tracklet_readout_if #(
    parameter int TRK_W = 32,
    parameter int CNT_W = 8
);
    logic             cnt_fifo_empty;
    logic [CNT_W-1:0] cnt_fifo_dout;
    logic             cnt_fifo_rd_en;
    logic             trk_fifo_empty;
    logic [TRK_W-1:0] trk_fifo_dout;
    logic             trk_fifo_rd_en;
    logic             out_valid;
    logic             out_ready;
    logic [TRK_W-1:0] out_data;
    logic             out_sop;
    logic             out_eop;
    logic             rdout_sm_bsy;
    logic             timeout_err;

    modport master (
        input  cnt_fifo_empty, cnt_fifo_dout, trk_fifo_empty, trk_fifo_dout, out_ready,
        output cnt_fifo_rd_en, trk_fifo_rd_en, out_valid, out_data, out_sop, out_eop,
               rdout_sm_bsy, timeout_err
    );

    modport slave (
        output cnt_fifo_empty, cnt_fifo_dout, trk_fifo_empty, trk_fifo_dout, out_ready,
        input  cnt_fifo_rd_en, trk_fifo_rd_en, out_valid, out_data, out_sop, out_eop,
               rdout_sm_bsy, timeout_err
    );
endinterface

// File: rtl/tracklet_readout_sm.sv
// Drains one crossing from the count/tracklet FWFT FIFOs into a header/data/trailer packet.
// Optional DATA-state starvation timeout: define TRK_READOUT_TIMEOUT_EN.
module tracklet_readout_sm #(
    parameter int TRK_W   = 32,
    parameter int CNT_W   = 8,
    parameter int BX_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                res,
    tracklet_readout_if.master  rd_if
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'b001,
        S_DATA    = 3'b010,
        S_TRAILER = 3'b100
    } state_t;

    state_t           r_state;
    logic [BX_W-1:0]  r_bx_cnt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_sent;
    logic             r_err;
    logic             r_out_valid;
    logic             r_out_sop;
    logic             r_out_eop;
    logic [TRK_W-1:0] r_out_data;

    logic             w_slot_free;
    logic             w_cnt_pop;
    logic             w_trk_pop;
    logic [TRK_W-1:0] w_header;
    logic [TRK_W-1:0] w_trailer;

    // Pops are combinational: an FWFT FIFO hands over its head word in the cycle rd_en is high.
    assign w_slot_free = !r_out_valid || rd_if.out_ready;
    assign w_cnt_pop   = !res && (r_state == S_IDLE) && !rd_if.cnt_fifo_empty && w_slot_free;
    assign w_trk_pop   = !res && (r_state == S_DATA) && !rd_if.trk_fifo_empty && w_slot_free;

    always_comb begin
        w_header                          = '0;
        w_header[TRK_W-1 -: 4]            = 4'b1010;
        w_header[BX_W+CNT_W-1:0]          = {r_bx_cnt, rd_if.cnt_fifo_dout};
        w_trailer                         = '0;
        w_trailer[TRK_W-1 -: 4]           = 4'b1100;
        w_trailer[TRK_W-5]                = r_err;
        w_trailer[BX_W+CNT_W-1:0]         = {r_bx_cnt, r_sent};
    end

`ifdef TRK_READOUT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            r_state     <= S_IDLE;
            r_bx_cnt    <= '0;
            r_remaining <= '0;
            r_sent      <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_data  <= '0;
`ifdef TRK_READOUT_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            // Accepted word retires; a load below in the same cycle re-asserts valid.
            if (rd_if.out_ready)
                r_out_valid <= 1'b0;
`ifdef TRK_READOUT_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_cnt_pop) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_header;
                        r_out_sop   <= 1'b1;
                        r_out_eop   <= 1'b0;
                        r_remaining <= rd_if.cnt_fifo_dout;
                        r_sent      <= '0;
`ifdef TRK_READOUT_TIMEOUT_EN
                        r_to_cnt    <= '0;
`endif
                        r_state     <= (rd_if.cnt_fifo_dout != '0) ? S_DATA : S_TRAILER;
                    end
                end
                S_DATA: begin
                    if (w_trk_pop) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= rd_if.trk_fifo_dout;
                        r_out_sop   <= 1'b0;
                        r_out_eop   <= 1'b0;
                        r_remaining <= r_remaining - CNT_W'(1);
                        r_sent      <= r_sent + CNT_W'(1);
`ifdef TRK_READOUT_TIMEOUT_EN
                        r_to_cnt    <= '0;
`endif
                        if (r_remaining == CNT_W'(1))
                            r_state <= S_TRAILER;
                    end
`ifdef TRK_READOUT_TIMEOUT_EN
                    else if (rd_if.trk_fifo_empty) begin
                        // Give up on the rest of the crossing; leftovers stay in the FIFO.
                        if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                            r_to_cnt      <= '0;
                            r_timeout_err <= 1'b1;
                            r_err         <= 1'b1;
                            r_state       <= S_TRAILER;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
`endif
                end
                S_TRAILER: begin
                    if (w_slot_free) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_trailer;
                        r_out_sop   <= 1'b0;
                        r_out_eop   <= 1'b1;
                        r_err       <= 1'b0;
                        r_bx_cnt    <= r_bx_cnt + BX_W'(1);
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_if.cnt_fifo_rd_en = w_cnt_pop;
    assign rd_if.trk_fifo_rd_en = w_trk_pop;
    assign rd_if.out_valid      = r_out_valid;
    assign rd_if.out_data       = r_out_data;
    assign rd_if.out_sop        = r_out_sop;
    assign rd_if.out_eop        = r_out_eop;
    assign rd_if.rdout_sm_bsy   = (r_state != S_IDLE);
`ifdef TRK_READOUT_TIMEOUT_EN
    assign rd_if.timeout_err    = r_timeout_err;
`else
    assign rd_if.timeout_err    = 1'b0;
`endif
endmodule

// File: tb/tb_tracklet_readout_sm.sv
// Directed bench for tracklet_readout_sm: FWFT FIFO models as queues, link words captured on acceptance.
module tb_tracklet_readout_sm;
    localparam int TRK_W   = 32;
    localparam int CNT_W   = 8;
    localparam int BX_W    = 8;
    localparam int TIMEOUT = 255;

    logic clk;
    logic res;

    tracklet_readout_if #(.TRK_W(TRK_W), .CNT_W(CNT_W)) ifc ();

    tracklet_readout_sm #(.TRK_W(TRK_W), .CNT_W(CNT_W), .BX_W(BX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .res   (res),
        .rd_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [CNT_W-1:0] cq[$];
    logic [TRK_W-1:0] tq[$];
    logic [TRK_W-1:0] rx_d[$];
    logic [1:0]       rx_f[$];
    int               rx_c[$];
    logic [TRK_W-1:0] exp_d[$];
    logic [1:0]       exp_f[$];

    int n_chk = 0, n_bad = 0;
    int cyc = 0, n_cnt_pop = 0, n_trk_pop = 0, n_viol = 0, to_seen = 0;
    int cnt_pop_cyc = 0, trk_pop_cyc = 0, to_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        ifc.cnt_fifo_empty = (cq.size() == 0);
        ifc.cnt_fifo_dout  = (cq.size() != 0) ? cq[0] : '0;
        ifc.trk_fifo_empty = (tq.size() == 0);
        ifc.trk_fifo_dout  = (tq.size() != 0) ? tq[0] : '0;
    endtask

    // Sample mid-cycle, then apply the pops the DUT made at the following edge.
    task automatic tick();
        logic c, t;
        @(negedge clk);
        c = ifc.cnt_fifo_rd_en;
        t = ifc.trk_fifo_rd_en;
        if (c) begin n_cnt_pop++; cnt_pop_cyc = cyc; end
        if (t) begin n_trk_pop++; trk_pop_cyc = cyc; end
        if (ifc.timeout_err) begin to_seen++; to_cyc = cyc; end
        if (ifc.out_valid && ifc.out_ready) begin
            rx_d.push_back(ifc.out_data);
            rx_f.push_back({ifc.out_sop, ifc.out_eop});
            rx_c.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (c) begin if (cq.size() == 0) n_viol++; else void'(cq.pop_front()); end
        if (t) begin if (tq.size() == 0) n_viol++; else void'(tq.pop_front()); end
        cyc++;
        refresh();
    endtask

    task automatic clr();
        rx_d.delete(); rx_f.delete(); rx_c.delete();
        exp_d.delete(); exp_f.delete();
        n_cnt_pop = 0; n_trk_pop = 0;
    endtask

    task automatic run(input string tag, input int n, input int budget);
        int k = 0;
        while (rx_d.size() < n && k < budget) begin tick(); k++; end
        chk({tag, "_words"}, rx_d.size(), n);
    endtask

    task automatic chk_stream(input string tag);
        for (int i = 0; i < exp_d.size(); i++) begin
            logic [TRK_W+1:0] got;
            got = (i < rx_d.size()) ? {rx_f[i], rx_d[i]} : 'x;
            chk($sformatf("%s[%0d]", tag, i), got, {exp_f[i], exp_d[i]});
        end
    endtask

    function automatic int span();
        return (rx_c.size() > 0) ? rx_c[rx_c.size()-1] - rx_c[0] : -1;
    endfunction

    initial begin
        res = 1'b1;
        ifc.out_ready = 1'b1;
        refresh();
        repeat (3) tick();
        chk("rst_valid", ifc.out_valid, 0);
        chk("rst_data",  ifc.out_data, 0);
        chk("rst_sopeop", {ifc.out_sop, ifc.out_eop}, 0);
        chk("rst_rden",  {ifc.cnt_fifo_rd_en, ifc.trk_fifo_rd_en}, 0);
        chk("rst_bsy",   ifc.rdout_sm_bsy, 0);
        chk("rst_to",    ifc.timeout_err, 0);
        res = 1'b0;

        // Three tracklets, full throughput
        clr();
        cq.push_back(8'd3);
        tq.push_back(32'h11); tq.push_back(32'h22); tq.push_back(32'h33);
        refresh();
        run("t1", 5, 40);
        exp_d = '{32'hA0000003, 32'h11, 32'h22, 32'h33, 32'hC0000003};
        exp_f = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
        chk_stream("t1");
        chk("t1_hdr_lat", (rx_c.size() > 0) ? rx_c[0] - cnt_pop_cyc : -1, 1);
        chk("t1_span", span(), 4);
        chk("t1_cnt_pops", n_cnt_pop, 1);
        chk("t1_trk_pops", n_trk_pop, 3);
        repeat (2) tick();

        // Empty crossing
        clr();
        cq.push_back(8'd0);
        refresh();
        run("t2", 2, 20);
        exp_d = '{32'hA0000100, 32'hC0000100};
        exp_f = '{2'b10, 2'b01};
        chk_stream("t2");
        chk("t2_span", span(), 1);
        chk("t2_trk_pops", n_trk_pop, 0);
        repeat (2) tick();

        // Downstream stall on the first data word
        begin
            int k = 0;
            bit found = 0;
            clr();
            cq.push_back(8'd2);
            tq.push_back(32'hAA); tq.push_back(32'hBB);
            refresh();
            while (!found && k < 20) begin
                tick(); k++;
                found = ifc.out_valid && (ifc.out_data == 32'hAA);
            end
            chk("t3_reach", found, 1);
            ifc.out_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                chk($sformatf("t3_hold%0d", i), {ifc.out_valid, ifc.out_data}, {1'b1, 32'hAA});
            end
            chk("t3_stall_pops", n_trk_pop, 1);
            ifc.out_ready = 1'b1;
            run("t3", 4, 20);
            exp_d = '{32'hA0000202, 32'hAA, 32'hBB, 32'hC0000202};
            exp_f = '{2'b10, 2'b00, 2'b00, 2'b01};
            chk_stream("t3");
            chk("t3_trk_pops", n_trk_pop, 2);
            repeat (2) tick();
        end

        // Reset in the middle of a packet
        begin
            int k = 0;
            clr();
            cq.push_back(8'd4);
            for (int i = 0; i < 4; i++) tq.push_back(32'h50 + i);
            refresh();
            while (n_trk_pop < 1 && k < 20) begin tick(); k++; end
            chk("t6_in_data", ifc.rdout_sm_bsy, 1);
            res = 1'b1;
            tick();
            chk("t6_valid", ifc.out_valid, 0);
            chk("t6_data", ifc.out_data, 0);
            chk("t6_sopeop", {ifc.out_sop, ifc.out_eop}, 0);
            chk("t6_rden", {ifc.cnt_fifo_rd_en, ifc.trk_fifo_rd_en}, 0);
            chk("t6_bsy", ifc.rdout_sm_bsy, 0);
            res = 1'b0;
            cq.delete(); tq.delete();
            clr();
            cq.push_back(8'd1);
            tq.push_back(32'h77);
            refresh();
            run("t6", 3, 20);
            exp_d = '{32'hA0000001, 32'h77, 32'hC0000001};
            exp_f = '{2'b10, 2'b00, 2'b01};
            chk_stream("t6");
            repeat (2) tick();
        end

        // 257 single-tracklet crossings from bx 0: bx wraps, link never idles
        res = 1'b1;
        tick();
        res = 1'b0;
        clr();
        for (int i = 0; i < 257; i++) begin
            logic [TRK_W-1:0] w;
            w = 32'h1000 + i;
            cq.push_back(8'd1);
            tq.push_back(w);
            exp_d.push_back(32'hA0000001 | ((i % 256) << 8)); exp_f.push_back(2'b10);
            exp_d.push_back(w);                                exp_f.push_back(2'b00);
            exp_d.push_back(32'hC0000001 | ((i % 256) << 8)); exp_f.push_back(2'b01);
        end
        refresh();
        run("t4", 771, 1200);
        chk_stream("t4");
        chk("t4_span", span(), 770);
        chk("t4_cnt_pops", n_cnt_pop, 257);
        repeat (2) tick();

`ifdef TRK_READOUT_TIMEOUT_EN
        // Five announced, two delivered: starve until timeout
        clr();
        to_seen = 0;
        cq.push_back(8'd5);
        tq.push_back(32'hE1); tq.push_back(32'hE2);
        refresh();
        run("t5", 4, 400);
        exp_d = '{32'hA0000105, 32'hE1, 32'hE2, 32'hC8000102};
        exp_f = '{2'b10, 2'b00, 2'b00, 2'b01};
        chk_stream("t5");
        chk("t5_to_pulses", to_seen, 1);
        chk("t5_to_delay", to_cyc - trk_pop_cyc, TIMEOUT + 1);
        repeat (2) tick();
`else
        chk("no_timeout", to_seen, 0);
`endif

        chk("rd_while_empty", n_viol, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
